// File: rtl/uart_mmio_pkg.sv
// Shared constants for the UART MMIO controller: register offsets, CON bit
// positions and the TX sequencer state encoding.
package uart_mmio_pkg;

   localparam logic [31:0] OFS_TXD = 32'd0;
   localparam logic [31:0] OFS_RXD = 32'd4;
   localparam logic [31:0] OFS_CON = 32'd8;

   localparam int CON_TX_IE    = 0;
   localparam int CON_RX_IE    = 1;
   localparam int CON_RX_READY = 2;
   localparam int CON_TX_FULL  = 3;
   localparam int CON_TX_DONE  = 4;
   localparam int CON_RX_OVR   = 5;
   localparam int CON_TX_OVR   = 6;

   typedef enum logic [1:0] {
      ST_IDLE      = 2'd0,
      ST_LAUNCH    = 2'd1,
      ST_WAIT_BUSY = 2'd2,
      ST_WAIT_DONE = 2'd3
   } tx_state_e;

endpackage

// File: rtl/uart_mmio_ctrl_sync_fifo.sv
// Single-clock FIFO with combinational head. A push into a full FIFO is
// accepted only when a pop frees a slot in the same cycle.
module sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     push,
   input  logic [WIDTH-1:0]         din,
   input  logic                     pop,
   output logic [WIDTH-1:0]         dout,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign full    = (count == (AW+1)'(DEPTH));
   assign empty   = (count == '0);
   assign dout    = mem[rd_ptr];
   assign do_pop  = pop & ~empty;
   assign do_push = push & (~full | do_pop);

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) begin
            mem[wr_ptr] <= din;
            wr_ptr      <= wr_ptr + 1'b1;
         end
         if (do_pop)
            rd_ptr <= rd_ptr + 1'b1;
         if (do_push && !do_pop)
            count <= count + 1'b1;
         else if (do_pop && !do_push)
            count <= count - 1'b1;
      end
   end

endmodule

// File: rtl/uart_mmio_ctrl.sv
// Memory-mapped UART controller: TXD/RXD/CON decode, RX and TX FIFOs, sticky
// status, the TX launch sequencer and a registered level interrupt.
module uart_mmio_ctrl
   import uart_mmio_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR  = 32'h40000018,
   parameter int          FIFO_DEPTH = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   input  logic        wr_en,
   input  logic        rd_en,
   output logic [31:0] rdata,
   input  logic        rx_valid,
   input  logic [7:0]  rx_data,
   input  logic        tx_busy,
   output logic        tx_start,
   output logic [7:0]  tx_data,
   output logic        irq,
   output tx_state_e   dbg_state
);

   localparam int CW = $clog2(FIFO_DEPTH) + 1;

   tx_state_e state;
   logic      sel_txd, sel_rxd, sel_con;
   logic      txd_wr, con_wr, rxd_rd, con_rd;
   logic      rx_pop, rx_full, rx_empty, tx_pop, tx_full, tx_empty;
   logic [7:0] rx_head, tx_head;
   logic [CW-1:0] unused_rx_count, unused_tx_count;
   logic      unused_wdata;
   logic      tx_ie, rx_ie, tx_done, rx_ovr, tx_ovr;
   logic      tx_done_set, rx_ovr_set, tx_ovr_set;

   assign sel_txd = (addr == BASE_ADDR + OFS_TXD);
   assign sel_rxd = (addr == BASE_ADDR + OFS_RXD);
   assign sel_con = (addr == BASE_ADDR + OFS_CON);
   assign txd_wr  = wr_en & sel_txd;
   assign con_wr  = wr_en & sel_con;
   assign rxd_rd  = rd_en & sel_rxd;
   assign con_rd  = rd_en & sel_con;
   assign unused_wdata = ^wdata[31:8];

   assign rx_pop      = rxd_rd & ~rx_empty;
   assign tx_pop      = (state == ST_LAUNCH);
   assign rx_ovr_set  = rx_valid & rx_full & ~rx_pop;
   assign tx_ovr_set  = txd_wr & tx_full & ~tx_pop;
   assign tx_done_set = (state == ST_WAIT_DONE) & ~tx_busy;
   assign dbg_state   = state;

   sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
      .clk(clk), .reset(reset), .push(rx_valid), .din(rx_data), .pop(rx_pop),
      .dout(rx_head), .full(rx_full), .empty(rx_empty), .count(unused_rx_count)
   );

   sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
      .clk(clk), .reset(reset), .push(txd_wr), .din(wdata[7:0]), .pop(tx_pop),
      .dout(tx_head), .full(tx_full), .empty(tx_empty), .count(unused_tx_count)
   );

   always_comb begin
      rdata = '0;
      if (sel_rxd && !rx_empty)
         rdata = {24'b0, rx_head};
      else if (sel_con)
         rdata = {25'b0, tx_ovr, rx_ovr, tx_done, tx_full, ~rx_empty, rx_ie, tx_ie};
   end

   // A set event in the same cycle as a clearing CON read keeps the bit high.
   always_ff @(posedge clk) begin
      if (reset) begin
         tx_ie   <= 1'b0;
         rx_ie   <= 1'b0;
         tx_done <= 1'b0;
         rx_ovr  <= 1'b0;
         tx_ovr  <= 1'b0;
         irq     <= 1'b0;
      end else begin
         if (con_wr) begin
            tx_ie <= wdata[CON_TX_IE];
            rx_ie <= wdata[CON_RX_IE];
         end
         tx_done <= tx_done_set | (tx_done & ~con_rd);
         rx_ovr  <= rx_ovr_set  | (rx_ovr  & ~con_rd);
         tx_ovr  <= tx_ovr_set  | (tx_ovr  & ~con_rd);
         irq     <= (rx_ie & ~rx_empty) | (tx_ie & tx_done);
      end
   end

   // Handshake with uart_tx: tx_start pulses for one cycle with tx_data valid;
   // tx_data stays stable until uart_tx raises and then drops tx_busy.
   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= ST_IDLE;
         tx_start <= 1'b0;
         tx_data  <= 8'h00;
      end else begin
         tx_start <= 1'b0;
         case (state)
            ST_IDLE: if (!tx_empty && !tx_busy) begin
               state    <= ST_LAUNCH;
               tx_start <= 1'b1;
               tx_data  <= tx_head;
            end
            ST_LAUNCH:    state <= ST_WAIT_BUSY;
            ST_WAIT_BUSY: if (tx_busy)  state <= ST_WAIT_DONE;
            ST_WAIT_DONE: if (!tx_busy) state <= ST_IDLE;
            default:      state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_uart_mmio_ctrl.sv
// Directed self-checking bench for uart_mmio_ctrl with a simple uart_tx model
// that raises tx_busy one cycle after tx_start for ten cycles.
module tb_uart_mmio_ctrl;
   import uart_mmio_pkg::*;

   localparam logic [31:0] A_TXD = 32'h40000018;
   localparam logic [31:0] A_RXD = 32'h4000001C;
   localparam logic [31:0] A_CON = 32'h40000020;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [31:0] addr = '0;
   logic [31:0] wdata = '0;
   logic        wr_en = 1'b0;
   logic        rd_en = 1'b0;
   logic [31:0] rdata;
   logic        rx_valid = 1'b0;
   logic [7:0]  rx_data = '0;
   logic        tx_busy;
   logic        tx_start;
   logic [7:0]  tx_data;
   logic        irq;
   tx_state_e   dbg_state;

   logic        model_busy = 1'b0;
   logic        hold_busy = 1'b0;
   int          n_checks = 0;
   int          n_fail = 0;
   int          launches = 0;
   logic [7:0]  exp_q[$];

   assign tx_busy = model_busy | hold_busy;

   uart_mmio_ctrl dut (
      .clk(clk), .reset(reset), .addr(addr), .wdata(wdata), .wr_en(wr_en),
      .rd_en(rd_en), .rdata(rdata), .rx_valid(rx_valid), .rx_data(rx_data),
      .tx_busy(tx_busy), .tx_start(tx_start), .tx_data(tx_data), .irq(irq),
      .dbg_state(dbg_state)
   );

   // clock / reset
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL global_timeout launches=%0d", launches);
      $fatal(1, "simulation time limit reached");
   end

   // uart_tx model and transmit scoreboard
   initial begin
      logic [7:0] exp_b;
      forever begin
         @(negedge clk);
         if (tx_start === 1'b1) begin
            launches++;
            n_checks++;
            if (exp_q.size() == 0) begin
               n_fail++;
               $display("FAIL tx_unexpected got=%02h expected=none", tx_data);
            end else begin
               exp_b = exp_q.pop_front();
               if (tx_data !== exp_b) begin
                  n_fail++;
                  $display("FAIL tx_byte got=%02h expected=%02h", tx_data, exp_b);
               end
            end
            @(negedge clk);
            model_busy = 1'b1;
            repeat (10) @(negedge clk);
            model_busy = 1'b0;
         end
      end
   end

   // driver tasks
   task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
      addr = a; wdata = d; wr_en = 1'b1;
      @(negedge clk);
      wr_en = 1'b0;
   endtask

   task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
      addr = a; rd_en = 1'b1;
      #1 d = rdata;
      @(negedge clk);
      rd_en = 1'b0;
   endtask

   task automatic rx_pulse(input logic [7:0] b);
      rx_valid = 1'b1; rx_data = b;
      @(negedge clk);
      rx_valid = 1'b0;
   endtask

   task automatic check_read(input string name, input logic [31:0] a, input logic [31:0] exp_v);
      logic [31:0] got;
      bus_read(a, got);
      n_checks++;
      if (got !== exp_v) begin
         n_fail++;
         $display("FAIL %s got=%08h expected=%08h", name, got, exp_v);
      end
   endtask

   task automatic wait_tx_idle(input int target);
      int i;
      for (i = 0; i < 400 && launches < target; i++) @(negedge clk);
      for (i = 0; i < 50 && !model_busy; i++) @(negedge clk);
      for (i = 0; i < 50 && !(dbg_state == ST_IDLE && !tx_busy); i++) @(negedge clk);
      @(negedge clk);
      n_checks++;
      if (launches !== target || dbg_state !== ST_IDLE) begin
         n_fail++;
         $display("FAIL tx_wait launches=%0d expected=%0d state=%0d", launches, target, dbg_state);
      end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      n_checks++;
      if (irq !== 1'b0 || tx_start !== 1'b0 || tx_data !== 8'h00 || dbg_state !== ST_IDLE) begin
         n_fail++;
         $display("FAIL reset_outputs irq=%b tx_start=%b tx_data=%02h state=%0d expected 0/0/00/0",
                  irq, tx_start, tx_data, dbg_state);
      end
      check_read("reset_con", A_CON, 32'h0);
      check_read("reset_rxd", A_RXD, 32'h0);
      check_read("unmapped_read", 32'h40000024, 32'h0);
      bus_write(32'h40000024, 32'h55);
      repeat (5) @(negedge clk);
      n_checks++;
      if (launches !== 0) begin
         n_fail++;
         $display("FAIL reset_no_launch launches=%0d expected=0", launches);
      end
   endtask

   task automatic test_single_tx();
      exp_q.push_back(8'h55);
      bus_write(A_TXD, 32'hAB55);
      wait_tx_idle(1);
      check_read("txd_reads_zero", A_TXD, 32'h0);
      check_read("tx_done_set", A_CON, 32'h10);
      check_read("tx_done_cleared", A_CON, 32'h0);
   endtask

   task automatic test_tx_overflow();
      hold_busy = 1'b1;
      for (int i = 0; i < 5; i++) begin
         if (i < 4) exp_q.push_back(8'h41 + 8'(i));
         bus_write(A_TXD, 32'h41 + i);
      end
      check_read("tx_full_ovr", A_CON, 32'h48);
      check_read("tx_ovr_cleared", A_CON, 32'h08);
      hold_busy = 1'b0;
      wait_tx_idle(5);
      check_read("tx_burst_done", A_CON, 32'h10);
      n_checks++;
      if (exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL tx_queue_drained left=%0d expected=0", exp_q.size());
      end
   endtask

   task automatic test_rx_irq();
      bus_write(A_CON, 32'h2);
      rx_pulse(8'h31);
      check_read("rx_ready", A_CON, 32'h06);
      n_checks++;
      if (irq !== 1'b1) begin
         n_fail++;
         $display("FAIL rx_irq_high got=%b expected=1", irq);
      end
      check_read("rx_byte", A_RXD, 32'h31);
      @(negedge clk);
      n_checks++;
      if (irq !== 1'b0) begin
         n_fail++;
         $display("FAIL rx_irq_low got=%b expected=0", irq);
      end
      bus_write(A_CON, 32'h0);
   endtask

   task automatic test_rx_overrun();
      logic [31:0] got;
      for (int i = 0; i < 5; i++) rx_pulse(8'h10 + 8'(i));
      for (int i = 0; i < 4; i++) check_read("rx_ovr_order", A_RXD, 32'h10 + i);
      check_read("rx_ovr_empty", A_RXD, 32'h0);
      check_read("rx_ovr_flag", A_CON, 32'h20);
      check_read("rx_ovr_cleared", A_CON, 32'h0);
      // fifth push coincides with a pop of a full FIFO
      for (int i = 0; i < 4; i++) rx_pulse(8'h10 + 8'(i));
      rx_valid = 1'b1; rx_data = 8'h14; addr = A_RXD; rd_en = 1'b1;
      #1 got = rdata;
      @(negedge clk);
      rx_valid = 1'b0; rd_en = 1'b0;
      n_checks++;
      if (got !== 32'h10) begin
         n_fail++;
         $display("FAIL rx_pop_push got=%08h expected=00000010", got);
      end
      for (int i = 1; i < 5; i++) check_read("rx_full_pushpop", A_RXD, 32'h10 + i);
      check_read("rx_no_ovr", A_CON, 32'h0);
   endtask

   task automatic test_empty_push_pop();
      logic [31:0] got;
      rx_valid = 1'b1; rx_data = 8'h77; addr = A_RXD; rd_en = 1'b1;
      #1 got = rdata;
      @(negedge clk);
      rx_valid = 1'b0; rd_en = 1'b0;
      n_checks++;
      if (got !== 32'h0) begin
         n_fail++;
         $display("FAIL rx_empty_pushpop got=%08h expected=00000000", got);
      end
      check_read("rx_empty_ready", A_CON, 32'h04);
      check_read("rx_empty_stored", A_RXD, 32'h77);
   endtask

   task automatic test_reset_mid_frame();
      int i;
      exp_q.push_back(8'h61);
      bus_write(A_TXD, 32'h61);
      bus_write(A_TXD, 32'h62);
      bus_write(A_TXD, 32'h63);
      for (i = 0; i < 50 && dbg_state != ST_WAIT_DONE; i++) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      n_checks++;
      if (dbg_state !== ST_IDLE || tx_start !== 1'b0) begin
         n_fail++;
         $display("FAIL mid_reset_state state=%0d tx_start=%b expected=0/0", dbg_state, tx_start);
      end
      check_read("mid_reset_con", A_CON, 32'h0);
      for (i = 0; i < 50 && model_busy; i++) @(negedge clk);
      repeat (20) @(negedge clk);
      n_checks++;
      if (launches !== 6) begin
         n_fail++;
         $display("FAIL mid_reset_no_launch launches=%0d expected=6", launches);
      end
      check_read("mid_reset_no_done", A_CON, 32'h0);
   endtask

   initial begin
      test_reset();
      test_single_tx();
      test_tx_overflow();
      test_rx_irq();
      test_rx_overrun();
      test_empty_push_pop();
      test_reset_mid_frame();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/uart_mmio_ctrl.md
Name: uart_mmio_ctrl

Overview:
- Memory-mapped UART controller between the pipelined CPU's peripheral bus and the UART serial engines (uart_rx, uart_tx).
- Buffers received bytes and CPU transmit bytes in FIFOs and sequences the TX engine through a start/busy handshake.
- Exposes TXD/RXD/CON registers and raises a level interrupt for the CPU's exception logic.

Parameters:
- BASE_ADDR, 32'h40000018, byte address of TXD. RXD is at BASE+4; CON is at BASE+8.
- FIFO_DEPTH, 4, entries per FIFO; power of two, at least 2.

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-high reset
- addr  input  32  CPU byte address
- wdata  input  32  CPU store data; bits [7:0] are used for TXD
- wr_en  input  1  store strobe, one cycle per access
- rd_en  input  1  load strobe, one cycle per access
- rdata  output  32  read data, combinational from addr and current state
- rx_valid  input  1  one-cycle pulse from uart_rx: byte received
- rx_data  input  8  received byte, valid with rx_valid
- tx_busy  input  1  uart_tx is shifting a frame
- tx_start  output  1  one-cycle launch pulse to uart_tx
- tx_data  output  8  byte for uart_tx, held stable from tx_start until tx_busy falls
- irq  output  1  level interrupt request

Behaviour:
- Reset (synchronous, active-high, on clk): both FIFOs empty, TX FSM in IDLE, all sticky bits 0, CON enable bits 0. Outputs tx_start=0, tx_data=0, irq=0.
- Reset mid-frame: drop the FIFOs and the FSM state. uart_tx finishes its frame independently.
- Address decode: exact word match only. Other addresses: reads return 0, writes are ignored, no side effects.
- TXD write: push wdata[7:0] into TX FIFO. If the FIFO is full, drop the byte and set tx_ovr. TXD read returns 0.
- RXD read: rdata = {24'b0, RX head}, and pop the head at the clock edge. Read when empty: return 0, no pop, no flag.
- rx_valid: push rx_data. If the FIFO is full and the same cycle has no RXD pop, drop the byte and set rx_ovr.
- Push and pop in the same cycle on a full RX FIFO: both succeed, count unchanged, no overrun.
- Push and pop in the same cycle on an empty RX FIFO: RXD read returns 0, the new byte is stored, count becomes 1.
- CON register:
  - bit0 tx_ie (RW)
  - bit1 rx_ie (RW)
  - bit2 rx_ready (RO, RX FIFO not empty)
  - bit3 tx_full (RO)
  - bit4 tx_done (sticky)
  - bit5 rx_ovr (sticky)
  - bit6 tx_ovr (sticky)
  - bits 31:7 read 0
- CON writes update bits [1:0] only.
- A CON read returns the current sticky values and clears bits 4-6 at the same edge. A set event in the same cycle as the clearing read wins: the bit stays 1.
- TX FSM states: IDLE, LAUNCH, WAIT_BUSY, WAIT_DONE.
  - IDLE: if the TX FIFO is non-empty and tx_busy=0, go to LAUNCH.
  - LAUNCH: tx_start=1 for exactly one cycle; tx_data=head; pop the head; go to WAIT_BUSY.
  - WAIT_BUSY: hold until tx_busy=1, then go to WAIT_DONE.
  - WAIT_DONE: on tx_busy=0, set tx_done and go to IDLE.
- Minimum spacing between tx_start pulses: LAUNCH + 1 busy cycle + 1 idle cycle.
- A TXD write while in IDLE with the FIFO empty produces tx_start two edges later. Edge 1: FIFO push. Edge 2: IDLE->LAUNCH. tx_start is asserted during the LAUNCH cycle.
- irq = (rx_ie & rx_ready) | (tx_ie & tx_done), registered, one cycle latency.
- FIFO pointers are log2(FIFO_DEPTH) bits and wrap naturally. The count is one bit wider. Full means count==FIFO_DEPTH.
- Simultaneous wr_en and rd_en: both are honoured, each decoded against addr.

Decomposition:
- Package uart_mmio_pkg:
  - register offsets (OFS_TXD=0, OFS_RXD=4, OFS_CON=8)
  - CON bit index constants
  - TX FSM state encoding (2-bit localparams/typedef)
- Sub-module sync_fifo (params WIDTH=8, DEPTH):
  - ports clk, reset, push, din, pop, dout (combinational head), full, empty, count
  - instantiated twice: RX FIFO and TX FIFO
- Top level holds decode, CON register, sticky bits, TX FSM and irq.

Test Plan:
- Reset released, then CON read -> rdata=0, irq=0, tx_start never pulses, RXD read returns 0.
- Write 0x55 to TXD; bench uart_tx model raises tx_busy 1 cycle after start for 10 cycles -> one tx_start pulse with tx_data=0x55; CON bit4=1 after busy falls; next CON read clears it.
- Write 0x41,0x42,0x43,0x44,0x45 back-to-back with busy engine -> first four transmitted in order; 0x45 dropped; CON bit6=1; tx_full observed =1 before the first launch pops.
- rx_valid with 0x31 and rx_ie=1 -> CON bit2=1 and irq=1 one cycle later; RXD read returns 0x31 and irq drops.
- Five rx_valid pulses 0x10..0x14 without reads -> reads return 0x10..0x13, then 0; rx_ovr=1. Repeat with an RXD pop coinciding with the 5th push -> no overrun, 0x14 retained.
- reset asserted during WAIT_DONE with 2 bytes queued -> next cycle FSM in IDLE, FIFOs empty, tx_start stays 0 after tx_busy falls, tx_done=0.
